// File: rtl/risc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : risc_controller_if
// Description : Bundles the CPU control bus between the phase sequencer and
//               the datapath blocks it steers (IR, ALU, PC, address mux,
//               memory, accumulator).
//               master : sequencer side. Samples opcode and zero. Drives the
//                        phase and all control strobes.
//               slave  : datapath side. Drives opcode and zero. Receives the
//                        phase and the strobes.
//               Signals:
//                 opcode  IR opcode field       zero    ALU accumulator-zero
//                 phase   current phase         sel     1 = PC address
//                 rd      memory read           ld_ir   load IR
//                 halt    CPU halted            inc_pc  increment PC
//                 ld_ac   load accumulator      ld_pc   load PC from IR addr
//                 wr      memory write          data_e  accumulator on bus
// Revision    : 1.0 - initial release
// ============================================================================
interface risc_controller_if #(
    parameter int OPCODE_W = 3,
    parameter int PHASE_W  = 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic [PHASE_W-1:0]  phase;
    logic                sel;
    logic                rd;
    logic                ld_ir;
    logic                halt;
    logic                inc_pc;
    logic                ld_ac;
    logic                ld_pc;
    logic                wr;
    logic                data_e;

    modport master (
        input  opcode, zero,
        output phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
    );

    modport slave (
        output opcode, zero,
        input  phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
    );
endinterface
`default_nettype wire

// File: rtl/risc_controller.sv
`default_nettype none
// ============================================================================
// Module      : risc_controller
// Description : Eight-phase instruction sequencer and control decoder for the
//               RISC CPU. The phase counter runs 0..7 and wraps. Control
//               strobes are decoded combinationally from the phase, the
//               opcode and the zero flag. A HLT freezes the sequencer in
//               phase 4 until reset.
// Ports       : clk  - system clock, rising edge active
//               rst  - asynchronous, active-high reset
//               bus  - risc_controller_if.master (opcode/zero in, phase and
//                      control strobes out)
// Revision    : 1.0 - initial release
// ============================================================================
module risc_controller #(
    parameter int OPCODE_W = 3,
    parameter int PHASE_W  = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    risc_controller_if.master     bus
);

    typedef enum logic [PHASE_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    localparam logic [OPCODE_W-1:0] C_OP_HLT = 3'd0;
    localparam logic [OPCODE_W-1:0] C_OP_SKZ = 3'd1;
    localparam logic [OPCODE_W-1:0] C_OP_ADD = 3'd2;
    localparam logic [OPCODE_W-1:0] C_OP_AND = 3'd3;
    localparam logic [OPCODE_W-1:0] C_OP_XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] C_OP_LDA = 3'd5;
    localparam logic [OPCODE_W-1:0] C_OP_STO = 3'd6;
    localparam logic [OPCODE_W-1:0] C_OP_JMP = 3'd7;

    phase_t r_phase;
    logic   r_halted;

    // Phase sequencer. On the edge that ends phase 4 of a HLT the halted flag
    // sets and the phase is held at 4, so the sequencer stays parked there
    // until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (r_phase == PH_OP_ADDR && bus.opcode == C_OP_HLT) begin
                r_halted <= 1'b1;
            end else begin
                r_phase <= phase_t'(r_phase + 1'b1);
            end
        end
    end

    logic w_aluop;
    logic w_is_sto;
    logic w_is_jmp;
    logic w_sel, w_rd, w_ld_ir, w_halt, w_inc_pc, w_ld_ac, w_ld_pc, w_wr, w_data_e;

    assign w_aluop  = (bus.opcode == C_OP_ADD) || (bus.opcode == C_OP_AND) ||
                      (bus.opcode == C_OP_XOR) || (bus.opcode == C_OP_LDA);
    assign w_is_sto = (bus.opcode == C_OP_STO);
    assign w_is_jmp = (bus.opcode == C_OP_JMP);

    // Control decode. The opcode is only consulted in phases 4-7, once the IR
    // has settled.
    always_comb begin
        w_sel    = 1'b0;
        w_rd     = 1'b0;
        w_ld_ir  = 1'b0;
        w_halt   = 1'b0;
        w_inc_pc = 1'b0;
        w_ld_ac  = 1'b0;
        w_ld_pc  = 1'b0;
        w_wr     = 1'b0;
        w_data_e = 1'b0;
        if (r_halted) begin
            // Parked: only halt is shown, so the PC stops after its one
            // increment in the first phase-4 cycle.
            w_halt = 1'b1;
        end else begin
            case (r_phase)
                PH_INST_ADDR: begin
                    w_sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    w_sel = 1'b1;
                    w_rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    w_sel   = 1'b1;
                    w_rd    = 1'b1;
                    w_ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    w_inc_pc = 1'b1;
                    w_halt   = (bus.opcode == C_OP_HLT);
                end
                PH_OP_FETCH: begin
                    w_rd = w_aluop;
                end
                PH_ALU_OP: begin
                    w_rd     = w_aluop;
                    // Second increment skips the next instruction when zero.
                    w_inc_pc = (bus.opcode == C_OP_SKZ) && bus.zero;
                    w_ld_pc  = w_is_jmp;
                    w_data_e = w_is_sto;
                end
                PH_STORE: begin
                    w_rd     = w_aluop;
                    w_ld_ac  = w_aluop;
                    w_ld_pc  = w_is_jmp;
                    w_wr     = w_is_sto;
                    w_data_e = w_is_sto;
                end
                default: begin
                    w_sel = 1'b0;
                end
            endcase
        end
    end

    assign bus.phase  = r_phase;
    assign bus.sel    = w_sel;
    assign bus.rd     = w_rd;
    assign bus.ld_ir  = w_ld_ir;
    assign bus.halt   = w_halt;
    assign bus.inc_pc = w_inc_pc;
    assign bus.ld_ac  = w_ld_ac;
    assign bus.ld_pc  = w_ld_pc;
    assign bus.wr     = w_wr;
    assign bus.data_e = w_data_e;

endmodule
`default_nettype wire

// File: tb/tb_risc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_controller
// Description : Directed testbench for risc_controller. Each instruction is
//               stepped phase by phase. The phase number and the packed
//               control word {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}
//               are compared against hand-computed tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_controller;

    typedef logic [8:0] ctrl_tab_t [8];

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    risc_controller_if #(.OPCODE_W(3), .PHASE_W(3)) bus ();

    risc_controller #(.OPCODE_W(3), .PHASE_W(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ctrl_word();
        return {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc,
                bus.ld_ac, bus.ld_pc, bus.wr, bus.data_e};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] act,
                             input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Checks phases 0..n-1 of one instruction, starting at the current phase
    // 0, then advancing one clock after each phase.
    task automatic run_instr(input string name, input logic [2:0] op,
                             input logic z, input ctrl_tab_t exp, input int n);
        bus.opcode = op;
        bus.zero   = z;
        for (int p = 0; p < n; p++) begin
            check_val($sformatf("%s phase p%0d", name, p), 16'(bus.phase), 16'(p));
            check_val($sformatf("%s ctrl p%0d", name, p), 16'(ctrl_word()), 16'(exp[p]));
            @(posedge clk);
            #1;
        end
    endtask

    ctrl_tab_t t_add, t_sto, t_skz1, t_skz0, t_jmp, t_hlt;

    initial begin
        n_vec = 0;
        n_bad = 0;
        //           p0           p1           p2           p3
        //           p4           p5           p6           p7
        t_add  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                   9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000};
        t_sto  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                   9'b000010000, 9'b000000000, 9'b000000001, 9'b000000011};
        t_skz1 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                   9'b000010000, 9'b000000000, 9'b000010000, 9'b000000000};
        t_skz0 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                   9'b000010000, 9'b000000000, 9'b000000000, 9'b000000000};
        t_jmp  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                   9'b000010000, 9'b000000000, 9'b000000100, 9'b000000100};
        t_hlt  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                   9'b000110000, 9'b000000000, 9'b000000000, 9'b000000000};

        rst        = 1'b1;
        bus.opcode = 3'd2;
        bus.zero   = 1'b0;
        #1;
        check_val("reset phase", 16'(bus.phase), 16'd0);
        check_val("reset ctrl", 16'(ctrl_word()), 16'(9'b100000000));
        @(posedge clk);
        #1;
        check_val("reset hold phase", 16'(bus.phase), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        run_instr("ADD", 3'd2, 1'b0, t_add, 8);
        run_instr("STO", 3'd6, 1'b0, t_sto, 8);
        run_instr("SKZ z1", 3'd1, 1'b1, t_skz1, 8);
        run_instr("SKZ z0", 3'd1, 1'b0, t_skz0, 8);
        run_instr("AND", 3'd3, 1'b1, t_add, 8);
        run_instr("JMP", 3'd7, 1'b0, t_jmp, 8);

        // JMP interrupted by reset in the middle of phase 6.
        run_instr("JMP part", 3'd7, 1'b0, t_jmp, 6);
        check_val("JMP p6 ld_pc", 16'(bus.ld_pc), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async rst phase", 16'(bus.phase), 16'd0);
        check_val("async rst ctrl", 16'(ctrl_word()), 16'(9'b100000000));
        @(negedge clk);
        rst = 1'b0;
        run_instr("post-rst ADD", 3'd2, 1'b0, t_add, 8);

        // HLT: parks at phase 4 with only halt asserted.
        run_instr("HLT", 3'd0, 1'b0, t_hlt, 5);
        for (int i = 0; i < 20; i++) begin
            check_val($sformatf("halted phase c%0d", i), 16'(bus.phase), 16'd4);
            check_val($sformatf("halted ctrl c%0d", i), 16'(ctrl_word()), 16'(9'b000100000));
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_val("halt rst phase", 16'(bus.phase), 16'd0);
        check_val("halt rst ctrl", 16'(ctrl_word()), 16'(9'b100000000));
        @(negedge clk);
        rst = 1'b0;
        run_instr("post-halt XOR", 3'd4, 1'b0, t_add, 8);
        run_instr("LDA", 3'd5, 1'b0, t_add, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Phase sequencer and control decoder for the RISC CPU; it initiates every transaction on the program counter interface.
- Runs a fixed 8-phase instruction cycle and decodes the 3-bit opcode from the instruction register.
- Drives `inc_pc` and `ld_pc` into `program_counter`, plus the memory/IR/accumulator control strobes.
- Sits between the instruction register, ALU zero flag, program counter, address mux, memory and accumulator.

Parameters:
- OPCODE_W, 3, opcode width; fixed at 3 for the current ISA.
- PHASE_W, 3, phase counter width; 8 phases, wraps.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- opcode  input  3  opcode field of the instruction register.
- zero  input  1  accumulator-is-zero flag from the ALU.
- phase  output  3  current phase, for debug and bench.
- sel  output  1  address mux select: 1 = PC address, 0 = IR operand address.
- rd  output  1  memory read enable.
- ld_ir  output  1  load instruction register.
- halt  output  1  CPU halted.
- inc_pc  output  1  increment program counter.
- ld_ac  output  1  load accumulator.
- ld_pc  output  1  load PC from IR address.
- wr  output  1  memory write strobe.
- data_e  output  1  drive accumulator onto the data bus.

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP is true for ADD, AND, XOR and LDA.
- Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Phase register advances by 1 on each rising clk and wraps 7->0. One instruction takes 8 cycles.
- Outputs are combinational from phase, opcode and zero. No registered outputs except phase and the halted flag. Any output not listed for a phase is 0.
  - Phase 0: sel=1.
  - Phase 1: sel=1, rd=1.
  - Phase 2: sel=1, rd=1, ld_ir=1.
  - Phase 3: sel=1, rd=1, ld_ir=1.
  - Phase 4: inc_pc=1; halt=(opcode==HLT).
  - Phase 5: rd=ALUOP.
  - Phase 6: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - Phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- `opcode` is sampled only in phases 4-7. IR is loaded by the end of phase 2, so opcode is stable from phase 3 onward.
- Halt: on the rising clk ending phase 4 with opcode==HLT, a halted flag sets.
  - While halted: phase freezes at 4, halt=1, all other outputs 0 (inc_pc is suppressed).
  - Only rst clears the halted flag.
  - PC is incremented exactly once before the halt takes effect, in the first phase-4 cycle.
- Reset (asynchronous, any time, including mid-instruction or while halted):
  - phase=0, halted=0.
  - Outputs immediately take phase-0 values: sel=1, all others 0.
  - Sequencing resumes at phase 0 on the first rising clk after rst deasserts.
- `zero` is sampled only in phase 6 and only for SKZ. SKZ with zero=0 produces a single increment (phase 4 only).
- JMP asserts ld_pc in both phases 6 and 7. The PC gives ld_pc priority, so repeated loads of the same address are harmless.
- inc_pc and ld_pc are never asserted in the same cycle.

Test Plan:
- Reset at t=0, release, run 8 clocks with opcode=ADD, zero=0:
  - phase sequence is 0..7 then 0.
  - sel=1 in phases 0-3; ld_ir=1 in phases 2-3; inc_pc=1 only in phase 4; rd=1 in phases 1-3 and 5-7; ld_ac=1 only in phase 7.
- opcode=STO for one full instruction:
  - data_e=1 in phases 6-7; wr=1 only in phase 7; rd=0 and ld_ac=0 in phases 5-7.
- opcode=SKZ:
  - with zero=1: inc_pc high in phases 4 and 6 (PC +2 through program_counter).
  - with zero=0: inc_pc high in phase 4 only (PC +1).
- opcode=JMP with ir_addr=5'b10101 into program_counter:
  - ld_pc=1 in phases 6-7.
  - pc_addr=10101 after phase 7; the next phase-0 address is 10101.
- opcode=HLT:
  - halt=1 in phase 4; phase stays 4 for 20 further clocks; inc_pc stays 0 after the first phase-4 cycle.
  - Then assert rst: phase=0, halt=0, sel=1 immediately, without waiting for a clock edge.
- Assert rst asynchronously mid-phase 6 of a JMP:
  - ld_pc drops to 0 within the same cycle; phase=0.
  - After release, a normal 0..7 sequence follows.
